// File: rtl/adc_pkg.sv
// Shared frame constants, state encoding and command-bit helper for the
// MCP3002-style serial ADC controller.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } adc_state_e;

  localparam int CMD_LEN   = 4;
  localparam int WAIT_LEN  = 3;
  localparam int SHIFT_LEN = 11;
  localparam int FRAME_LEN = 18;
  localparam int SAMPLE_W  = 10;
  localparam int CNT_W     = 5;

  localparam logic SGL_BIT  = 1'b1;
  localparam logic MSBF_BIT = 1'b1;

  // Counter values holding the number of edges already taken in the frame
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(CMD_LEN + WAIT_LEN - 1);
  localparam logic [CNT_W-1:0] NULL_CNT   = CNT_W'(CMD_LEN + WAIT_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  function automatic logic cmd_bit(input logic [1:0] idx, input logic ch);
    logic b;
    case (idx)
      2'd0:    b = 1'b1;
      2'd1:    b = SGL_BIT;
      2'd2:    b = ch;
      2'd3:    b = MSBF_BIT;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_serial_ctrl.sv
// Frames one ADC conversion per 18 serial-clock edges: command out on DIN,
// null bit plus 10 LSB-first data bits in on DOUT, one-cycle ready strobe.
module adc_serial_ctrl
  import adc_pkg::*;
(
  input  logic                s_clk_i,
  input  logic                rst_n_i,
  input  logic                start_sample_i,
  input  logic                channel_num_i,
  output logic                cs_o,
  output logic                din_o,
  input  logic                dout_i,
  output logic                data_ready_o,
  output logic [SAMPLE_W-1:0] data_o
);

  adc_state_e          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                ch_r, ch_s;
  logic                cs_r, cs_s;
  logic                din_r, din_s;
  logic                rdy_r, rdy_s;
  logic [SAMPLE_W-1:0] shreg_r, shreg_s;
  logic [SAMPLE_W-1:0] data_r, data_s;

  // Next-state and next-output decode; cnt_r counts edges already taken in the frame
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ch_s    = ch_r;
    cs_s    = cs_r;
    din_s   = 1'b0;
    rdy_s   = 1'b0;
    shreg_s = shreg_r;
    data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (start_sample_i) begin
          state_s = ST_CMD;
          cnt_s   = 5'd1;
          ch_s    = channel_num_i;
          cs_s    = 1'b0;
          din_s   = cmd_bit(2'd0, channel_num_i);
        end else begin
          cnt_s = 5'd0;
          cs_s  = 1'b1;
        end
      end
      ST_CMD: begin
        cnt_s = cnt_r + 5'd1;
        din_s = cmd_bit(cnt_r[1:0], ch_r);
        if (cnt_r == CMD_LAST) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r + 5'd1;
        if (cnt_r == WAIT_LAST) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SHIFT: begin
        cnt_s = cnt_r + 5'd1;
        // The first DOUT bit after the wait window is the ADC null bit
        if (cnt_r == NULL_CNT) begin
          shreg_s = shreg_r;
        end else begin
          shreg_s = {dout_i, shreg_r[SAMPLE_W-1:1]};
        end
        if (cnt_r == FRAME_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = 5'd0;
          cs_s    = 1'b1;
          rdy_s   = 1'b1;
          data_s  = {dout_i, shreg_r[SAMPLE_W-1:1]};
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 5'd0;
        cs_s    = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge s_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      ch_r    <= 1'b0;
      cs_r    <= 1'b1;
      din_r   <= 1'b0;
      rdy_r   <= 1'b0;
      shreg_r <= 10'd0;
      data_r  <= 10'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ch_r    <= ch_s;
      cs_r    <= cs_s;
      din_r   <= din_s;
      rdy_r   <= rdy_s;
      shreg_r <= shreg_s;
      data_r  <= data_s;
    end
  end

  assign cs_o         = cs_r;
  assign din_o        = din_r;
  assign data_ready_o = rdy_r;
  assign data_o       = data_r;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Self-checking bench for adc_serial_ctrl: frame-level reference model with
// randomized words, channels, start drops, gaps and a mid-frame reset abort.
module tb_adc_serial_ctrl;

  logic       s_clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_sample_i;
  logic       channel_num_i;
  logic       cs_o;
  logic       din_o;
  logic       dout_i;
  logic       data_ready_o;
  logic [9:0] data_o;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int last_strobe = -1000;
  logic [9:0] exp_data = 10'd0;

  adc_serial_ctrl dut (
    .s_clk_i        (s_clk_i),
    .rst_n_i        (rst_n_i),
    .start_sample_i (start_sample_i),
    .channel_num_i  (channel_num_i),
    .cs_o           (cs_o),
    .din_o          (din_o),
    .dout_i         (dout_i),
    .data_ready_o   (data_ready_o),
    .data_o         (data_o)
  );

  always #5 s_clk_i = ~s_clk_i;

  always @(posedge s_clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_cs"},   16'(cs_o),         16'd1);
    check_val({tag, "_din"},  16'(din_o),        16'd0);
    check_val({tag, "_rdy"},  16'(data_ready_o), 16'd0);
    check_val({tag, "_data"}, 16'(data_o),       16'(exp_data));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge s_clk_i);
      start_sample_i = 1'b0;
      channel_num_i  = 1'($urandom);
      dout_i         = 1'($urandom);
      @(posedge s_clk_i);
      #1;
      check_idle_outputs("idle");
    end
  endtask

  // One frame as seen from the pins: edge e = 1..18, e==1 is the start edge.
  // drop_edge: start deasserted from that edge on (0 = held). abort_edge: reset
  // asserted mid-cycle before that edge (0 = none). check_gap: previous strobe
  // was 18 edges earlier.
  task automatic run_frame(input logic ch, input logic [9:0] word, input int drop_edge,
                           input int abort_edge, input bit check_gap);
    logic exp_din;
    int   idx;
    for (int e = 1; e <= 18; e++) begin
      @(negedge s_clk_i);
      if (e == abort_edge) begin
        rst_n_i        = 1'b0;
        start_sample_i = 1'b0;
        exp_data       = 10'd0;
        #1;
        check_idle_outputs("abort");
        repeat (2) begin
          @(posedge s_clk_i);
          #1;
          check_idle_outputs("abort_hold");
        end
        @(negedge s_clk_i);
        rst_n_i = 1'b1;
        return;
      end
      start_sample_i = (e == 1) ? 1'b1 : ((drop_edge != 0 && e >= drop_edge) ? 1'b0 : 1'b1);
      channel_num_i  = (e == 1) ? ch : 1'($urandom);
      idx            = (e >= 9) ? (e - 9) : 0;
      dout_i         = (e >= 9) ? word[idx] : 1'($urandom);
      @(posedge s_clk_i);
      #1;
      case (e)
        1:       exp_din = 1'b1;
        2:       exp_din = 1'b1;
        3:       exp_din = ch;
        4:       exp_din = 1'b1;
        default: exp_din = 1'b0;
      endcase
      check_val("cs",  16'(cs_o),         (e == 18) ? 16'd1 : 16'd0);
      check_val("din", 16'(din_o),        16'(exp_din));
      check_val("rdy", 16'(data_ready_o), (e == 18) ? 16'd1 : 16'd0);
      if (e == 18) begin
        exp_data = word;
        if (check_gap) check_val("strobe_gap", 16'(cyc - last_strobe), 16'd18);
        last_strobe = cyc;
      end
      check_val("data", 16'(data_o), 16'(exp_data));
    end
  endtask

  initial begin
    int   gap;
    bit   have_prev;
    logic ch;
    logic [9:0] w;
    int   drop;

    rst_n_i        = 1'b0;
    start_sample_i = 1'b0;
    channel_num_i  = 1'b0;
    dout_i         = 1'b0;
    repeat (3) @(posedge s_clk_i);
    #1;
    check_idle_outputs("reset");
    @(negedge s_clk_i);
    rst_n_i = 1'b1;
    idle_cycles(2);

    run_frame(1'b1, 10'h001, 0, 0, 1'b0);
    idle_cycles(1);
    run_frame(1'b0, 10'h3FF, 0, 0, 1'b0);
    idle_cycles(1);

    run_frame(1'($urandom), 10'h2AA, 0, 0, 1'b0);
    run_frame(1'($urandom), 10'h155, 0, 0, 1'b1);
    run_frame(1'($urandom), 10'h0F0, 0, 0, 1'b1);
    idle_cycles(2);

    run_frame(1'($urandom), 10'($urandom), 6, 0, 1'b0);
    idle_cycles(4);

    have_prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      gap  = $urandom_range(0, 2);
      ch   = 1'($urandom);
      w    = 10'($urandom);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 18) : 0;
      if (gap > 0) idle_cycles(gap);
      run_frame(ch, w, drop, 0, have_prev && gap == 0);
      have_prev = 1'b1;
    end
    idle_cycles(2);

    run_frame(1'b1, 10'h3C5, 0, 12, 1'b0);
    idle_cycles(3);
    run_frame(1'b0, 10'h1A7, 0, 0, 1'b0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
